// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM state, config-select codes and mode/EOI bit positions for the PIC.
package pic_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACK1 = 2'd1, ACK2 = 2'd2} pic_state_e;
  localparam logic [1:0] SEL_IMR  = 2'd0;
  localparam logic [1:0] SEL_BASE = 2'd1;
  localparam logic [1:0] SEL_MODE = 2'd2;
  localparam logic [1:0] SEL_EOI  = 2'd3;
  localparam int MODE_LTIM = 0;
  localparam int MODE_AEOI = 1;
  localparam int MODE_ROT  = 2;
  localparam int EOI_SPEC  = 7;
endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: picks the highest-priority unmasked request that outranks every in-service bit.
module pic_priority_resolver #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [ID_W-1:0]    rot_base,
  output logic               win_valid,
  output logic [ID_W-1:0]    win_id
);
  logic [ID_W:0]   s;
  logic [ID_W-1:0] idx;
  logic            blocked;
  // Walk channels in priority order starting at rot_base; the first in-service bit ends the search.
  always_comb begin
    win_valid = 1'b0;
    win_id = '0;
    blocked = 1'b0;
    s = '0;
    idx = '0;
    for (int p = 0; p < NUM_IRQ; p++) begin
      s = {1'b0, rot_base} + (ID_W+1)'(p);
      idx = (s >= (ID_W+1)'(NUM_IRQ)) ? ID_W'(s - (ID_W+1)'(NUM_IRQ)) : ID_W'(s);
      if (!win_valid && !blocked) begin
        if (isr[idx]) blocked = 1'b1;
        else if (req[idx] && !mask[idx]) begin
          win_valid = 1'b1;
          win_id = idx;
        end
      end
    end
  end
endmodule

// File: rtl/pic_core_param.sv
// pic_core_param: parameterised 8259-style interrupt controller with two-edge INTA handshake.
// Define PIC_ROTATE_EN to build rotating priority (mode bit2) and the last_serviced register.
module pic_core_param #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [31:0]        cfg_wdata,
  input  logic               inta_n,
  output logic               int_out,
  output logic [VEC_W-1:0]   vec_out,
  output logic               vec_valid,
  output logic [NUM_IRQ-1:0] irr_o,
  output logic [NUM_IRQ-1:0] isr_o
);
  import pic_pkg::*;
  localparam int ID_W = $clog2(NUM_IRQ);
  localparam logic [VEC_W-1:0] ID_MASK = VEC_W'((1 << ID_W) - 1);
  localparam logic [ID_W-1:0]  SPUR_ID = ID_W'(NUM_IRQ - 1);
  pic_state_e state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, isr_set, isr_clr;
  logic [VEC_W-1:0]   base_q, base_d, vec_q, vec_d;
  logic [ID_W-1:0]    id_q, id_d, win_id, top_id, rot_base;
  logic ltim_q, ltim_d, aeoi_q, aeoi_d, spur_q, spur_d, int_out_q, int_out_d, vec_valid_q, vec_valid_d;
  logic inta_prev_q, fall, ack_first, ack_second, eoi_we, eoi_ns, eoi_sp, aeoi_hit, win_valid, top_valid;
  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_win (
    .req(irr_q), .mask(imr_q), .isr(isr_q), .rot_base(rot_base),
    .win_valid(win_valid), .win_id(win_id)
  );
  // Highest-priority in-service bit, used by non-specific EOI.
  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_top (
    .req(isr_q), .mask('0), .isr('0), .rot_base(rot_base),
    .win_valid(top_valid), .win_id(top_id)
  );
`ifdef PIC_ROTATE_EN
  logic            rot_q, rot_d;
  logic [ID_W-1:0] ls_q, ls_d;
  assign rot_base = rot_q ? ((ls_q == SPUR_ID) ? '0 : ls_q + 1'b1) : '0;
  always_comb begin
    rot_d = (cfg_we && cfg_sel == SEL_MODE) ? cfg_wdata[MODE_ROT] : rot_q;
    ls_d = (aeoi_hit && rot_q) ? id_q : (eoi_ns && top_valid && rot_q) ? top_id : ls_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_q <= 1'b0;
      ls_q <= SPUR_ID;
    end else begin
      rot_q <= rot_d;
      ls_q <= ls_d;
    end
  end
`else
  assign rot_base = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // ACK2 is unreachable; any unexpected encoding falls back to IDLE.
  always_comb begin
    state_d = (state_q == IDLE) ? (fall ? ACK1 : IDLE) : (state_q == ACK1 && !fall) ? ACK1 : IDLE;
  end
  always_comb begin
    fall = inta_prev_q & ~inta_n;
    ack_first = (state_q == IDLE) & fall;
    ack_second = (state_q == ACK1) & fall;
    eoi_we = cfg_we & (cfg_sel == SEL_EOI);
    eoi_ns = eoi_we & ~cfg_wdata[EOI_SPEC];
    eoi_sp = eoi_we & cfg_wdata[EOI_SPEC] & (int'(cfg_wdata[ID_W-1:0]) < NUM_IRQ);
    aeoi_hit = ack_second & aeoi_q & ~spur_q;
    isr_set = (ack_first && win_valid) ? NUM_IRQ'(1) << win_id : '0;
    isr_clr = (eoi_sp ? NUM_IRQ'(1) << cfg_wdata[ID_W-1:0] : '0)
            | ((eoi_ns && top_valid) ? NUM_IRQ'(1) << top_id : '0)
            | (aeoi_hit ? NUM_IRQ'(1) << id_q : '0);
    isr_d = (isr_q & ~isr_clr) | isr_set;
    irr_d = ltim_q ? irq_in : (irr_q & ~isr_set) | (irq_in & ~irq_prev_q);
    imr_d = (cfg_we && cfg_sel == SEL_IMR) ? cfg_wdata[NUM_IRQ-1:0] : imr_q;
    base_d = (cfg_we && cfg_sel == SEL_BASE) ? cfg_wdata[VEC_W-1:0] : base_q;
    ltim_d = (cfg_we && cfg_sel == SEL_MODE) ? cfg_wdata[MODE_LTIM] : ltim_q;
    aeoi_d = (cfg_we && cfg_sel == SEL_MODE) ? cfg_wdata[MODE_AEOI] : aeoi_q;
    id_d = ack_first ? (win_valid ? win_id : SPUR_ID) : id_q;
    spur_d = ack_first ? ~win_valid : spur_q;
    int_out_d = win_valid & (state_q == IDLE) & ~fall;
    vec_d = ack_second ? (base_q & ~ID_MASK) | VEC_W'(id_q) : vec_q;
    vec_valid_d = ack_second;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      inta_prev_q <= 1'b1;
      irr_q <= '0;
      isr_q <= '0;
      imr_q <= '0;
      base_q <= '0;
      ltim_q <= 1'b0;
      aeoi_q <= 1'b0;
      id_q <= '0;
      spur_q <= 1'b0;
      int_out_q <= 1'b0;
      vec_q <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      irq_prev_q <= irq_in;
      inta_prev_q <= inta_n;
      irr_q <= irr_d;
      isr_q <= isr_d;
      imr_q <= imr_d;
      base_q <= base_d;
      ltim_q <= ltim_d;
      aeoi_q <= aeoi_d;
      id_q <= id_d;
      spur_q <= spur_d;
      int_out_q <= int_out_d;
      vec_q <= vec_d;
      vec_valid_q <= vec_valid_d;
    end
  end
  assign int_out = int_out_q;
  assign vec_out = vec_q;
  assign vec_valid = vec_valid_q;
  assign irr_o = irr_q;
  assign isr_o = isr_q;
endmodule

// File: tb/tb_pic_core_param.sv
// tb_pic_core_param: directed vectors for pic_core_param (NUM_IRQ=8, VEC_W=8).
module tb_pic_core_param;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        inta_n;
  logic        int_out, vec_valid;
  logic [7:0]  vec_out, irr_o, isr_o;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] v;
  logic       vv_hi, vv_after;
  logic [7:0] exp_ids [4];
  pic_core_param #(.NUM_IRQ(8), .VEC_W(8)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .inta_n(inta_n), .int_out(int_out), .vec_out(vec_out),
    .vec_valid(vec_valid), .irr_o(irr_o), .isr_o(isr_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_wdata = data;
    step();
    cfg_we = 1'b0;
  endtask
  task automatic inta_pair(output logic [7:0] vec, output logic hi, output logic after);
    inta_n = 1'b0;
    step();
    inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    step();
    vec = vec_out;
    hi = vec_valid;
    inta_n = 1'b1;
    step();
    after = vec_valid;
  endtask
  initial begin
    reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0; inta_n = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_int_out", int_out, 0);
    chk("rst_vec_out", vec_out, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_irr", irr_o, 0);
    chk("rst_isr", isr_o, 0);
    // Edge-triggered request on channel 4
    cfg(2'd1, 32'hF8);
    irq_in = 8'h10;
    step();
    chk("edge_irr", irr_o, 8'h10);
    chk("edge_int_lat1", int_out, 0);
    step();
    chk("edge_int_lat2", int_out, 1);
    inta_pair(v, vv_hi, vv_after);
    chk("ack4_vec", v, 8'hFC);
    chk("ack4_valid", vv_hi, 1);
    chk("ack4_valid_1cyc", vv_after, 0);
    chk("ack4_hold", vec_out, 8'hFC);
    chk("ack4_isr", isr_o, 8'h10);
    chk("ack4_irr", irr_o, 0);
    chk("ack4_int_low", int_out, 0);
    // Fully nested: lower channels wait for EOI of 4
    irq_in = 8'hD0;
    step();
    step();
    step();
    chk("nest_irr", irr_o, 8'hC0);
    chk("nest_int_blocked", int_out, 0);
    cfg(2'd3, 32'h0);
    chk("ns_eoi_isr", isr_o, 0);
    step();
    chk("nest_int_after_eoi", int_out, 1);
    inta_pair(v, vv_hi, vv_after);
    chk("ack6_vec", v, 8'hFE);
    chk("ack6_isr", isr_o, 8'h40);
    chk("ack6_irr", irr_o, 8'h80);
    cfg(2'd3, 32'h86);
    chk("sp_eoi6_isr", isr_o, 0);
    inta_pair(v, vv_hi, vv_after);
    chk("ack7_vec", v, 8'hFF);
    chk("ack7_isr", isr_o, 8'h80);
    irq_in = 8'h00;
    cfg(2'd3, 32'h87);
    chk("sp_eoi7_isr", isr_o, 0);
    step();
    chk("idle_int_low", int_out, 0);
    // Masking
    cfg(2'd0, 32'h02);
    irq_in = 8'h02;
    step();
    chk("mask_irr", irr_o, 8'h02);
    step();
    step();
    chk("mask_int_low", int_out, 0);
    cfg(2'd0, 32'h00);
    step();
    chk("unmask_int_high", int_out, 1);
    inta_pair(v, vv_hi, vv_after);
    chk("ack1_vec", v, 8'hF9);
    cfg(2'd3, 32'h0);
    irq_in = 8'h00;
    step();
    chk("eoi1_isr", isr_o, 0);
    // Spurious acknowledge
    inta_pair(v, vv_hi, vv_after);
    chk("spur_vec", v, 8'hFF);
    chk("spur_valid", vv_hi, 1);
    chk("spur_isr", isr_o, 0);
    // Reset in the middle of the handshake
    irq_in = 8'h08;
    step();
    step();
    chk("pre_abort_int", int_out, 1);
    inta_n = 1'b0;
    step();
    chk("pre_abort_isr", isr_o, 8'h08);
    inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    irq_in = 8'h00;
    reset = 1'b1;
    step();
    chk("abort_vec_valid", vec_valid, 0);
    chk("abort_vec_out", vec_out, 0);
    chk("abort_int_out", int_out, 0);
    chk("abort_isr", isr_o, 0);
    chk("abort_irr", irr_o, 0);
    reset = 1'b0;
    inta_n = 1'b1;
    step();
    irq_in = 8'h20;
    step();
    step();
    chk("post_rst_int", int_out, 1);
    inta_pair(v, vv_hi, vv_after);
    chk("post_rst_vec", v, 8'h05);
    chk("post_rst_valid", vv_hi, 1);
    cfg(2'd3, 32'h0);
    chk("post_rst_eoi", isr_o, 0);
    // Level + AEOI + rotate (rotation only honoured when built in)
`ifdef PIC_ROTATE_EN
    exp_ids = '{8'd1, 8'd2, 8'd1, 8'd2};
`else
    exp_ids = '{8'd1, 8'd1, 8'd1, 8'd1};
`endif
    cfg(2'd2, 32'h7);
    irq_in = 8'h06;
    step();
    chk("level_irr", irr_o, 8'h06);
    step();
    for (int i = 0; i < 4; i++) begin
      inta_pair(v, vv_hi, vv_after);
      chk("rot_vec", v, exp_ids[i]);
      chk("aeoi_isr", isr_o, 0);
    end
    chk("level_irr_kept", irr_o, 8'h06);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
